// File: rtl/instr_prefetch_queue_if.sv
// Bundle of the fetch-memory handshake, the redirect port and the IF-stage pop port.
// master = prefetch queue, slave = memory/IF/branch side.
interface instr_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          mem_req_o;
  logic [31:0]   mem_addr_o;
  logic          mem_ack_i;
  logic [31:0]   mem_rdata_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          instr_valid_o;
  logic [31:0]   instr_o;
  logic [31:0]   instr_pc_o;
  logic          instr_ready_i;
  logic [CW-1:0] count_o;

  modport master (
    output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o,
    input  mem_ack_i, mem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o,
    output mem_ack_i, mem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, keeps one word read in flight
// to instruction memory, and buffers {instr, pc} pairs for the IF stage.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  instr_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [31:0]     fpc_reg, fpc_next;
  logic [31:0]     addr_reg, addr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic            push, pop, wr_en, head_valid;
  logic [DEPTH-1:0][31:0] instr_arr, pc_arr;

  // Acked data only counts as a push while the request belongs to fpc (REQ).
  assign push       = (state_reg == REQ) && bus.mem_ack_i;
  assign head_valid = (count_reg != '0);
  assign pop        = head_valid && bus.instr_ready_i;
  assign wr_en      = push && !bus.redirect_i;

  always_comb begin
    state_next  = state_reg;
    fpc_next    = fpc_reg;
    addr_next   = addr_reg;
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;

    if (bus.redirect_i) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      fpc_next    = {bus.redirect_pc_i[31:2], 2'b00};
      // An unacked request cannot be withdrawn; hold its address and drop its data later.
      if (state_reg != IDLE && !bus.mem_ack_i) begin
        state_next = DRAIN;
      end else begin
        state_next = REQ;
        addr_next  = fpc_next;
      end
    end else begin
      count_next = count_reg + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
        fpc_next    = fpc_reg + 32'd4;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      unique case (state_reg)
        IDLE: begin
          if (count_next < DEPTH_C) begin
            state_next = REQ;
            addr_next  = fpc_next;
          end
        end
        REQ: begin
          if (bus.mem_ack_i) begin
            if (count_next < DEPTH_C) begin
              addr_next = fpc_next;
            end else begin
              state_next = IDLE;
            end
          end
        end
        DRAIN: begin
          if (bus.mem_ack_i) begin
            state_next = REQ;
            addr_next  = fpc_reg;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      fpc_reg    <= RESET_PC;
      addr_reg   <= RESET_PC;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      fpc_reg    <= fpc_next;
      addr_reg   <= addr_next;
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Entry storage needs no reset: the head is masked whenever the count is zero.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] instr_reg;
      logic [31:0] pc_reg;
      always_ff @(posedge clk_i) begin
        if (wr_en && (wr_ptr_reg == PW'(gi))) begin
          instr_reg <= bus.mem_rdata_i;
          pc_reg    <= fpc_reg;
        end
      end
      assign instr_arr[gi] = instr_reg;
      assign pc_arr[gi]    = pc_reg;
    end
  endgenerate

  assign bus.mem_req_o     = (state_reg != IDLE);
  assign bus.mem_addr_o    = addr_reg;
  assign bus.instr_valid_o = head_valid;
  assign bus.instr_o       = head_valid ? instr_arr[rd_ptr_reg] : 32'd0;
  assign bus.instr_pc_o    = head_valid ? pc_arr[rd_ptr_reg] : 32'd0;
  assign bus.count_o       = count_reg;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed phases against a queue-based model
// checked every cycle, plus hand-computed expectations at key points.
module tb_instr_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  instr_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int ack_lat  = 0;
  int wait_cnt = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  bit          m_busy;
  bit          m_stale;
  logic [31:0] m_addr;
  logic [31:0] m_fpc;
  bit          model_on = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain queue of fetched words plus "request outstanding" / "data is stale" flags.
  task automatic model_step(input bit rst, input bit ack, input bit ready,
                            input bit redir, input logic [31:0] rpc);
    bit acked;
    bit popped;
    if (rst) begin
      m_q.delete();
      m_busy  = 1'b0;
      m_stale = 1'b0;
      m_fpc   = RESET_PC;
      m_addr  = RESET_PC;
      return;
    end
    acked  = m_busy && ack;
    popped = (m_q.size() != 0) && ready;
    if (redir) begin
      m_q.delete();
      m_fpc = rpc & 32'hFFFF_FFFC;
      if (m_busy && !ack) begin
        m_stale = 1'b1;
      end else begin
        m_busy  = 1'b1;
        m_stale = 1'b0;
        m_addr  = m_fpc;
      end
    end else begin
      if (popped) begin
        $display("pop pc=%08h instr=%08h", m_q[0].pc, m_q[0].instr);
        void'(m_q.pop_front());
      end
      if (acked && !m_stale) begin
        m_q.push_back({mem_word(m_fpc), m_fpc});
        m_fpc = m_fpc + 32'd4;
      end
      if (acked && m_stale) begin
        m_stale = 1'b0;
        m_addr  = m_fpc;
      end else if (!m_busy || acked) begin
        if (m_q.size() < DEPTH) begin
          m_busy = 1'b1;
          m_addr = m_fpc;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  endtask

  // One clock: memory responds, edge, model advances with the same inputs.
  task automatic tick();
    bit ack_now;
    bit req_now;
    req_now = (bus.mem_req_o === 1'b1);
    if (ack_lat == 0) ack_now = 1'b1;
    else              ack_now = req_now && (wait_cnt == ack_lat);
    bus.mem_ack_i   = ack_now;
    bus.mem_rdata_i = mem_word(bus.mem_addr_o);
    @(posedge clk_i);
    model_step(rst_i, ack_now, bus.instr_ready_i, bus.redirect_i, bus.redirect_pc_i);
    if (rst_i || !req_now || ack_now) wait_cnt = 0;
    else                              wait_cnt++;
    #1;
  endtask

  always @(negedge clk_i) begin
    if (model_on) begin
      chk("mem_req",     32'(bus.mem_req_o),     32'(m_busy));
      chk("mem_addr",    bus.mem_addr_o,         m_addr);
      chk("instr_valid", 32'(bus.instr_valid_o), 32'(m_q.size() != 0));
      chk("instr",       bus.instr_o,            (m_q.size() != 0) ? m_q[0].instr : 32'd0);
      chk("instr_pc",    bus.instr_pc_o,         (m_q.size() != 0) ? m_q[0].pc : 32'd0);
      chk("count",       32'(bus.count_o),       32'(m_q.size()));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(bus.mem_req_o),     32'd0);
    chk({tag, "_addr"},  bus.mem_addr_o,         RESET_PC);
    chk({tag, "_valid"}, 32'(bus.instr_valid_o), 32'd0);
    chk({tag, "_instr"}, bus.instr_o,            32'd0);
    chk({tag, "_pc"},    bus.instr_pc_o,         32'd0);
    chk({tag, "_count"}, 32'(bus.count_o),       32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst_i             = 1'b1;
    bus.mem_ack_i     = 1'b0;
    bus.mem_rdata_i   = 32'd0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'd0;
    bus.instr_ready_i = 1'b0;

    // Reset, then zero-wait streaming with ready high.
    tick();
    tick();
    model_on = 1'b1;
    chk_reset_outputs("reset");
    rst_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    ack_lat = 0;
    tick();
    chk("first_req",  32'(bus.mem_req_o), 32'd1);
    chk("first_addr", bus.mem_addr_o, 32'h0);
    chk("first_empty", 32'(bus.instr_valid_o), 32'd0);
    tick();
    chk("first_pc",    bus.instr_pc_o, 32'h0);
    chk("first_instr", bus.instr_o, 32'hC001_D00D);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("stream_pc",    bus.instr_pc_o, 32'(4 * i));
      chk("stream_instr", bus.instr_o, mem_word(32'(4 * i)));
    end

    // Backpressure: fill to DEPTH, request drops, then drain in order.
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("full_count", 32'(bus.count_o), 32'd4);
    chk("full_noreq", 32'(bus.mem_req_o), 32'd0);
    bus.instr_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("drain_pc", bus.instr_pc_o, 32'h18 + 32'(4 * i));
    end
    for (int i = 0; i < 10; i++) begin
      bus.instr_ready_i = i[0];
      tick();
    end

    // Three-cycle memory latency.
    ack_lat = 3;
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 24; i++) tick();

    // Redirect to 0x40 while the request for 0x8 is outstanding and unacked.
    rst_i = 1'b1;
    bus.instr_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_req_o && bus.mem_addr_o == 32'h8) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("reach_addr8", 32'(found), 32'd1);
    tick();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h40;
    tick();
    bus.redirect_i = 1'b0;
    chk("drain_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("drain_count", 32'(bus.count_o), 32'd0);
    chk("drain_req",   32'(bus.mem_req_o), 32'd1);
    chk("drain_addr",  bus.mem_addr_o, 32'h8);
    bus.instr_ready_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_valid_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("redir40_arrives", 32'(found), 32'd1);
    chk("redir40_pc",    bus.instr_pc_o, 32'h40);
    chk("redir40_instr", bus.instr_o, mem_word(32'h40));

    // Redirect to 0x100 coinciding with an ack and a pop.
    ack_lat = 0;
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("steady_count", 32'(bus.count_o), 32'd1);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    tick();
    bus.redirect_i = 1'b0;
    chk("r100_empty", 32'(bus.instr_valid_o), 32'd0);
    chk("r100_addr",  bus.mem_addr_o, 32'h100);
    tick();
    chk("r100_pc",    bus.instr_pc_o, 32'h100);
    chk("r100_instr", bus.instr_o, mem_word(32'h100));

    // Unaligned redirect near the top of the address space wraps to zero.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFE;
    tick();
    bus.redirect_i = 1'b0;
    chk("wrap_addr", bus.mem_addr_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc_top", bus.instr_pc_o, 32'hFFFF_FFFC);
    chk("wrap_addr0",  bus.mem_addr_o, 32'h0);
    tick();
    chk("wrap_pc_zero",    bus.instr_pc_o, 32'h0);
    chk("wrap_instr_zero", bus.instr_o, 32'hC001_D00D);

    // Reset mid-stream with a request outstanding.
    bus.instr_ready_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst_i = 1'b0;
    tick();
    chk("post_rst_req",  32'(bus.mem_req_o), 32'd1);
    chk("post_rst_addr", bus.mem_addr_o, 32'h0);
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    @(posedge clk_i);
    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
